// File: rtl/dpi_stream_sequencer.sv
// rtl/dpi_stream_sequencer.sv - regex lane front end: save/restore, stream and drain sequencing per packet
// Tracks a per-stream enable mask and seen bitmap and frames each packet for the matcher.
module dpi_stream_sequencer #(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [63:0] ENABLE_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  output logic        in_ready,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [7:0]  in_data,
  input  logic [5:0]  in_sid,
  input  logic        cfg_wr,
  input  logic [5:0]  cfg_addr,
  input  logic        cfg_en,
  input  logic        cfg_clr_all,
  output logic        load_state,
  output logic [5:0]  stream_id,
  output logic        new_stream_id,
  output logic        enable,
  output logic [7:0]  char_in,
  output logic        char_in_vld,
  output logic        eop,
  output logic        busy,
  output logic [15:0] drop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_STREAM,
    S_DRAIN,
    S_EOP
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t      r_state;
  logic [63:0] r_seen;
  logic [63:0] r_mask;
  logic [3:0]  r_drain_cnt;
  logic        r_stream_rdy;
  logic        r_idle_rdy;
  logic        w_stray;

  // Strays must be swallowed in the cycle they appear while a sop beat must be
  // left waiting, so the idle half of in_ready is qualified by the live beat.
  assign w_stray  = r_idle_rdy & in_vld & ~in_sop;
  assign in_ready = r_stream_rdy | w_stray;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_drain_cnt   <= '0;
      r_stream_rdy  <= 1'b0;
      r_idle_rdy    <= 1'b0;
      load_state    <= 1'b0;
      stream_id     <= '0;
      new_stream_id <= 1'b0;
      enable        <= 1'b0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      busy          <= 1'b0;
      drop_count    <= '0;
    end else begin
      load_state    <= 1'b0;
      new_stream_id <= 1'b0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      if (w_stray && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          r_idle_rdy <= 1'b1;
          if (in_vld && in_sop) begin
            r_state       <= S_LOAD;
            r_idle_rdy    <= 1'b0;
            busy          <= 1'b1;
            load_state    <= 1'b1;
            stream_id     <= in_sid;
            new_stream_id <= ~r_seen[in_sid];
            enable        <= r_mask[in_sid];
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_state      <= S_STREAM;
          r_stream_rdy <= 1'b1;
        end
        S_STREAM: begin
          if (in_vld) begin
            char_in     <= in_data;
            char_in_vld <= 1'b1;
            if (in_eop) begin
              r_state      <= S_DRAIN;
              r_stream_rdy <= 1'b0;
              r_drain_cnt  <= DRAIN_INIT;
            end
          end
        end
        S_DRAIN: begin
          // First DRAIN cycle still shows the last char, then DRAIN_CYCLES idle cycles.
          if (r_drain_cnt == 4'd0) begin
            r_state <= S_EOP;
            eop     <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
        S_EOP: begin
          r_state    <= S_IDLE;
          busy       <= 1'b0;
          r_idle_rdy <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen <= '0;
      r_mask <= ENABLE_RESET;
    end else begin
      if (cfg_wr) begin
        r_mask[cfg_addr] <= cfg_en;
      end
      if (cfg_clr_all) begin
        r_seen <= '0;
      end else if (r_state == S_EOP && enable) begin
        r_seen[stream_id] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb/tb_dpi_stream_sequencer.sv - directed vector bench for dpi_stream_sequencer
module tb_dpi_stream_sequencer;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld, in_sop, in_eop;
  logic [7:0]  in_data;
  logic [5:0]  in_sid;
  logic        cfg_wr, cfg_en, cfg_clr_all;
  logic [5:0]  cfg_addr;
  logic        in_ready, load_state, new_stream_id, enable, char_in_vld, eop, busy;
  logic [5:0]  stream_id;
  logic [7:0]  char_in;
  logic [15:0] drop_count;

  int n_chk = 0;
  int n_err = 0;

  dpi_stream_sequencer #(.DRAIN_CYCLES(D), .ENABLE_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_ready(in_ready), .in_sop(in_sop),
    .in_eop(in_eop), .in_data(in_data), .in_sid(in_sid), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_clr_all(cfg_clr_all),
    .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
    .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld, sop, eop;
    logic [7:0] data;
    logic [5:0] sid;
    logic       cwr, cen;
    logic [5:0] cad;
    logic       rdy, ld, nw;
    logic [5:0] osid;
    logic       en;
    logic [7:0] ch;
    logic       cv, ep, bsy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic vld, sop, eop, input logic [7:0] d, input logic [5:0] sid,
                              input logic cwr, cen, input logic [5:0] cad,
                              input logic rdy, ld, nw, input logic [5:0] osid, input logic en,
                              input logic [7:0] ch, input logic cv, ep, bsy);
    vec_t v;
    v.vld = vld; v.sop = sop; v.eop = eop; v.data = d; v.sid = sid;
    v.cwr = cwr; v.cen = cen; v.cad = cad;
    v.rdy = rdy; v.ld = ld; v.nw = nw; v.osid = osid; v.en = en;
    v.ch = ch; v.cv = cv; v.ep = ep; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_vld = 0; in_sop = 0; in_eop = 0; in_data = 0; in_sid = 0;
    cfg_wr = 0; cfg_en = 0; cfg_addr = 0; cfg_clr_all = 0;
  endtask

  task automatic send_pkt(input logic [5:0] sid, input int len, input logic exp_new,
                          input logic exp_en, input bit clr_at_eop, input bit mid_wr);
    int k;
    in_vld = 1; in_sop = 1; in_eop = (len == 1); in_sid = sid; in_data = 8'h10;
    tick();
    chk("pkt_load", load_state, 1);
    chk("pkt_new", new_stream_id, exp_new);
    chk("pkt_sid", stream_id, sid);
    tick();
    chk("pkt_wait_load", load_state, 0);
    tick();
    for (int i = 0; i < len; i++) begin
      in_vld = 1; in_sop = (i == 0); in_eop = (i == len - 1); in_data = 8'(8'h10 + i);
      if (mid_wr && i == 1) begin
        cfg_wr = 1; cfg_addr = sid; cfg_en = 0;
      end
      #1 chk("pkt_rdy", in_ready, 1);
      tick();
      cfg_wr = 0;
      chk("pkt_cv", char_in_vld, 1);
      chk("pkt_ch", char_in, 8'(8'h10 + i));
    end
    in_vld = 0; in_sop = 0; in_eop = 0;
    k = 0;
    while (eop !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("pkt_eop_lat", 16'(k), 16'(D + 1));
    chk("pkt_eop_en", enable, exp_en);
    chk("pkt_eop_sid", stream_id, sid);
    if (clr_at_eop) cfg_clr_all = 1;
    tick();
    cfg_clr_all = 0;
    chk("pkt_eop_end", eop, 0);
    chk("pkt_idle", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_load", load_state, 0);
    chk("rst_sid", stream_id, 0);
    chk("rst_en", enable, 0);
    chk("rst_cv", char_in_vld, 0);
    chk("rst_eop", eop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    rst_n = 1;

    tv.push_back(mk(1,1,0,8'h61,5, 0,0,0, 0,0,0,0,0,8'h00,0,0,0));
    tv.push_back(mk(1,1,0,8'h61,5, 0,0,0, 0,1,1,5,1,8'h00,0,0,1));
    tv.push_back(mk(1,1,0,8'h61,5, 0,0,0, 0,0,0,5,1,8'h00,0,0,1));
    tv.push_back(mk(1,1,0,8'h61,5, 0,0,0, 1,0,0,5,1,8'h00,0,0,1));
    tv.push_back(mk(1,0,0,8'h62,5, 0,0,0, 1,0,0,5,1,8'h61,1,0,1));
    tv.push_back(mk(1,0,1,8'h63,5, 0,0,0, 1,0,0,5,1,8'h62,1,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,5,1,8'h63,1,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,5,1,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,5,1,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,5,1,8'h00,0,1,1));
    tv.push_back(mk(1,1,1,8'h78,5, 0,0,0, 0,0,0,5,1,8'h00,0,0,0));
    tv.push_back(mk(1,1,1,8'h78,5, 0,0,0, 0,1,0,5,1,8'h00,0,0,1));
    tv.push_back(mk(1,1,1,8'h78,5, 0,0,0, 0,0,0,5,1,8'h00,0,0,1));
    tv.push_back(mk(1,1,1,8'h78,5, 0,0,0, 1,0,0,5,1,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 1,0,7, 0,0,0,5,1,8'h78,1,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,5,1,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,5,1,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,5,1,8'h00,0,1,1));
    tv.push_back(mk(1,1,0,8'h70,7, 0,0,0, 0,0,0,0,0,8'h00,0,0,0));
    tv.push_back(mk(1,1,0,8'h70,7, 0,0,0, 0,1,1,7,0,8'h00,0,0,1));
    tv.push_back(mk(1,1,0,8'h70,7, 0,0,0, 0,0,0,7,0,8'h00,0,0,1));
    tv.push_back(mk(1,1,0,8'h70,7, 0,0,0, 1,0,0,7,0,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 1,0,0,7,0,8'h70,1,0,1));
    tv.push_back(mk(1,0,0,8'h71,7, 0,0,0, 1,0,0,7,0,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 1,0,0,7,0,8'h71,1,0,1));
    tv.push_back(mk(1,0,1,8'h72,7, 0,0,0, 1,0,0,7,0,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,7,0,8'h72,1,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,7,0,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,7,0,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,7,0,8'h00,0,1,1));
    tv.push_back(mk(1,1,1,8'h73,7, 0,0,0, 0,0,0,0,0,8'h00,0,0,0));
    tv.push_back(mk(1,1,1,8'h73,7, 0,0,0, 0,1,1,7,0,8'h00,0,0,1));
    tv.push_back(mk(1,1,1,8'h73,7, 0,0,0, 0,0,0,7,0,8'h00,0,0,1));
    tv.push_back(mk(1,1,1,8'h73,7, 0,0,0, 1,0,0,7,0,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,7,0,8'h73,1,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,7,0,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,7,0,8'h00,0,0,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,7,0,8'h00,0,1,1));
    tv.push_back(mk(0,0,0,8'h00,0, 0,0,0, 0,0,0,0,0,8'h00,0,0,0));

    foreach (tv[i]) begin
      in_vld = tv[i].vld; in_sop = tv[i].sop; in_eop = tv[i].eop;
      in_data = tv[i].data; in_sid = tv[i].sid;
      cfg_wr = tv[i].cwr; cfg_en = tv[i].cen; cfg_addr = tv[i].cad;
      #1;
      chk($sformatf("row%0d_rdy", i), in_ready, tv[i].rdy);
      chk($sformatf("row%0d_load", i), load_state, tv[i].ld);
      chk($sformatf("row%0d_new", i), new_stream_id, tv[i].nw);
      chk($sformatf("row%0d_cv", i), char_in_vld, tv[i].cv);
      chk($sformatf("row%0d_eop", i), eop, tv[i].ep);
      chk($sformatf("row%0d_busy", i), busy, tv[i].bsy);
      if (tv[i].cv) chk($sformatf("row%0d_ch", i), char_in, tv[i].ch);
      if (tv[i].bsy) begin
        chk($sformatf("row%0d_sid", i), stream_id, tv[i].osid);
        chk($sformatf("row%0d_en", i), enable, tv[i].en);
      end
      tick();
    end
    idle_inputs();

    send_pkt(9, 2, 1, 1, 1, 0);
    send_pkt(9, 1, 1, 1, 0, 0);
    send_pkt(5, 1, 1, 1, 0, 0);

    send_pkt(10, 3, 1, 1, 0, 1);
    send_pkt(10, 1, 0, 0, 0, 0);

    in_vld = 1; in_sop = 0; in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stray_rdy", in_ready, 1);
      tick();
      chk("stray_noload", load_state, 0);
    end
    in_vld = 0;
    #1;
    chk("stray_count3", drop_count, 3);
    chk("stray_busy", busy, 0);
    chk("stray_rdy_off", in_ready, 0);
    in_vld = 1;
    repeat (70000) tick();
    in_vld = 0;
    tick();
    chk("stray_sat", drop_count, 16'hFFFF);

    in_vld = 1; in_sop = 1; in_eop = 0; in_sid = 5; in_data = 8'h41;
    tick(); tick(); tick();
    tick();
    in_sop = 0; in_data = 8'h42;
    chk("rst_mid_cv", char_in_vld, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_ready", in_ready, 0);
    chk("arst_load", load_state, 0);
    chk("arst_sid", stream_id, 0);
    chk("arst_en", enable, 0);
    chk("arst_cv", char_in_vld, 0);
    chk("arst_busy", busy, 0);
    chk("arst_drop", drop_count, 0);
    in_vld = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_noeop", eop, 0);
    end
    rst_n = 1;
    tick();
    chk("post_rst_eop", eop, 0);
    send_pkt(5, 2, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
